param_acc_cpu: RTL and testbench
================================

PARAM_ACC_CPU -- requirements
Module: param_acc_cpu

Interface
REQ-001 Parameter DW, default 8, data/instruction word width; SHALL satisfy DW >= AW+4.
REQ-002 Parameter AW, default 4, memory address width; memory depth SHALL be 2^AW words of DW bits.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  run request, sampled only in IDLE or HALT.
REQ-006 mem_we  input  1  program-load write strobe.
REQ-007 mem_addr  input  AW  load/debug address.
REQ-008 mem_wdata  input  DW  load data.
REQ-009 mem_rdata  output  DW  combinational M[mem_addr], valid in every state.
REQ-010 ac  output  DW  accumulator.
REQ-011 pc  output  AW  program counter.
REQ-012 carry  output  1  carry/borrow flag.
REQ-013 zero  output  1  combinational (ac == 0).
REQ-014 running  output  1  high in FETCH0..EXECUTE.
REQ-015 halted  output  1  high in HALT only.

Function
REQ-016 Instruction format: bit DW-1 = I (indirect), bits DW-2..DW-4 = opcode, bits AW-1..0 = address; remaining bits ignored.
REQ-017 States: IDLE, FETCH0, FETCH1, DECODE, INDIRECT, EXECUTE, HALT; one state per cycle, every instruction exactly 5 cycles.
REQ-018 IDLE/HALT: start=1 -> FETCH0 with pc<=0; else hold.
REQ-019 FETCH0: AR<=pc. FETCH1: IR<=M[AR], pc<=pc+1 modulo 2^AW (2^AW-1 wraps to 0).
REQ-020 DECODE: latch I, opcode; AR<=IR[AW-1:0].
REQ-021 INDIRECT: if I=1, AR<=M[AR][AW-1:0]; if I=0, AR unchanged; always proceeds to EXECUTE.
REQ-022 EXECUTE ops (EA=AR), all arithmetic modulo 2^DW: 000 ADD ac<=ac+M[EA], carry<=carry-out; 001 SUB ac<=ac-M[EA], carry<=borrow; 010 XOR ac<=ac^M[EA]; 011 DBL M[EA]<=M[EA]<<1, carry<=old MSB; 100 LDA ac<=M[EA]; 101 STA M[EA]<=ac; 110 CMA M[EA]<=~M[EA].
REQ-023 Opcode 111, I=0: JZ -- if ac==0, pc<=IR[AW-1:0] (direct; no indirection), else pc unchanged.
REQ-024 Opcode 111, I=1: HLT -- next state HALT; no register change.
REQ-025 All non-HLT EXECUTE -> FETCH0; carry changes only on ADD/SUB/DBL.
REQ-026 mem_we writes M[mem_addr]<=mem_wdata only in IDLE or HALT; ignored while running.
REQ-027 mem_we and start in same cycle: both take effect; write visible to first fetch.
REQ-028 STA/DBL/CMA to the address of a later instruction SHALL modify that instruction (self-modifying code permitted).

Reset
REQ-029 rst_n=0 at clock edge: state<=IDLE, ac<=0, pc<=0, carry<=0, AR<=0, IR<=0; priority over start and mem_we.
REQ-030 Memory contents SHALL NOT be reset; reset mid-instruction aborts it with no memory write.
REQ-031 Outputs after reset: running=0, halted=0, zero=1, carry=0.

Verification (DW=8, AW=4)
REQ-032 Load M0=4E, M1=0F, M2=F0, M14=F0, M15=20; start -> halted rises exactly 15 cycles after start edge, ac=10, carry=1, pc=3.
REQ-033 Indirect: M0=CD, M1=F0, M13=09, M9=77; start -> ac=77, carry=0, halted.
REQ-034 M0=4A, M1=3B, M2=6B, M3=5C, M4=F0, M10=81, M11=C4: ac=81; DBL M11 -> 88, carry=1; CMA M11 -> 77; M12=81 via mem_rdata.
REQ-035 JZ: ac=0 with M0=7E -> pc=14 next fetch; ac!=0 -> pc=1; instruction at M15 (non-branch) -> pc wraps to 0.
REQ-036 rst_n low during EXECUTE of STA -> target word unchanged, state IDLE, ac=0; mem_we while running -> memory unchanged.

Source files
------------

// File: rtl/param_acc_cpu.sv
// Multicycle accumulator CPU with 2^AW x DW unified program/data memory.
// Every instruction takes FETCH0..EXECUTE (5 cycles); parameters must satisfy DW >= AW+4.
module param_acc_cpu #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ac,
    output logic [AW-1:0] pc,
    output logic          carry,
    output logic          zero,
    output logic          running,
    output logic          halted
);
    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_DBL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_DECODE,
        S_INDIRECT,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_ac;
    logic [DW-1:0] r_ir;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ar;
    logic          r_carry;
    logic          r_ind;
    logic [2:0]    r_op;

    logic [DW-1:0] w_rd_ar;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic          w_mem_wr;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;
    logic          w_is_hlt;
    logic          w_unused_ir;

    assign w_rd_ar     = r_mem[r_ar];
    assign w_sum       = {1'b0, r_ac} + {1'b0, w_rd_ar};
    assign w_diff      = {1'b0, r_ac} - {1'b0, w_rd_ar};
    assign w_is_hlt    = (r_op == OP_JMP) && r_ind;
    assign w_unused_ir = ^r_ir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the single memory write port (host load or EXECUTE store).
    always_comb begin
        w_state_nxt = r_state;
        w_mem_wr    = 1'b0;
        w_mem_waddr = mem_addr;
        w_mem_wdata = mem_wdata;
        case (r_state)
            S_IDLE, S_HALT: begin
                w_mem_wr = mem_we;
                if (start) begin
                    w_state_nxt = S_FETCH0;
                end
            end
            S_FETCH0:   w_state_nxt = S_FETCH1;
            S_FETCH1:   w_state_nxt = S_DECODE;
            S_DECODE:   w_state_nxt = S_INDIRECT;
            S_INDIRECT: w_state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                w_state_nxt = w_is_hlt ? S_HALT : S_FETCH0;
                w_mem_waddr = r_ar;
                case (r_op)
                    OP_DBL: begin
                        w_mem_wr    = 1'b1;
                        w_mem_wdata = {w_rd_ar[DW-2:0], 1'b0};
                    end
                    OP_STA: begin
                        w_mem_wr    = 1'b1;
                        w_mem_wdata = r_ac;
                    end
                    OP_CMA: begin
                        w_mem_wr    = 1'b1;
                        w_mem_wdata = ~w_rd_ar;
                    end
                    default: ;
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory is never cleared; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_wr) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ac    <= '0;
            r_pc    <= '0;
            r_carry <= 1'b0;
            r_ar    <= '0;
            r_ir    <= '0;
            r_ind   <= 1'b0;
            r_op    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc <= '0;
                    end
                end
                S_FETCH0: r_ar <= r_pc;
                S_FETCH1: begin
                    r_ir <= w_rd_ar;
                    r_pc <= r_pc + AW'(1);
                end
                S_DECODE: begin
                    r_ind <= r_ir[DW-1];
                    r_op  <= r_ir[DW-2:DW-4];
                    r_ar  <= r_ir[AW-1:0];
                end
                S_INDIRECT: begin
                    if (r_ind) begin
                        r_ar <= w_rd_ar[AW-1:0];
                    end
                end
                S_EXECUTE: begin
                    case (r_op)
                        OP_ADD: {r_carry, r_ac} <= w_sum;
                        OP_SUB: {r_carry, r_ac} <= w_diff;
                        OP_XOR: r_ac <= r_ac ^ w_rd_ar;
                        OP_DBL: r_carry <= w_rd_ar[DW-1];
                        OP_LDA: r_ac <= w_rd_ar;
                        OP_JMP: begin
                            // JZ target is always the direct address field
                            if (!r_ind && (r_ac == '0)) begin
                                r_pc <= r_ir[AW-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign mem_rdata = r_mem[mem_addr];
    assign ac        = r_ac;
    assign pc        = r_pc;
    assign carry     = r_carry;
    assign zero      = (r_ac == '0);
    assign running   = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_param_acc_cpu.sv
// Bench for param_acc_cpu (DW=8, AW=4): instruction-level reference model compared
// every cycle, plus directed programs with hand-computed results.
module tb_param_acc_cpu;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] ac;
    logic [3:0] pc;
    logic       carry;
    logic       zero;
    logic       running;
    logic       halted;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    param_acc_cpu #(.DW(8), .AW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .ac       (ac),
        .pc       (pc),
        .carry    (carry),
        .zero     (zero),
        .running  (running),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=halt; an instruction's effect lands on its 5th edge
    logic [7:0] m_mem [16];
    logic [7:0] m_ac;
    logic [3:0] m_pc;
    logic       m_carry;
    int         m_mode;
    int         m_phase;
    logic [7:0] m_ir;
    logic [7:0] m_v;
    logic [3:0] m_a;
    logic [3:0] m_ea;
    logic [2:0] m_op;
    logic       m_ind;
    int         m_s;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_ac    = 8'h00;
            m_pc    = 4'h0;
            m_carry = 1'b0;
            m_phase = 0;
        end else if (m_mode != 1) begin
            if (mem_we) m_mem[mem_addr] = mem_wdata;
            if (start) begin
                m_mode  = 1;
                m_pc    = 4'h0;
                m_phase = 0;
            end
        end else if (m_phase == 4) begin
            m_ind = m_ir[7];
            m_op  = m_ir[6:4];
            m_a   = m_ir[3:0];
            m_ea  = m_ind ? m_mem[m_a][3:0] : m_a;
            m_v   = m_mem[m_ea];
            case (m_op)
                3'd0: begin
                    m_s     = int'(m_ac) + int'(m_v);
                    m_carry = (m_s > 255);
                    m_ac    = 8'(m_s);
                end
                3'd1: begin
                    m_carry = (m_ac < m_v);
                    m_ac    = m_ac - m_v;
                end
                3'd2: m_ac = m_ac ^ m_v;
                3'd3: begin
                    m_carry      = m_v[7];
                    m_mem[m_ea]  = 8'(int'(m_v) * 2);
                end
                3'd4: m_ac = m_v;
                3'd5: m_mem[m_ea] = m_ac;
                3'd6: m_mem[m_ea] = ~m_v;
                default: begin
                    if (m_ind) m_mode = 2;
                    else if (m_ac == 8'h00) m_pc = m_a;
                end
            endcase
            m_phase = 0;
        end else begin
            if (m_phase == 1) begin
                m_ir = m_mem[m_pc];
                m_pc = m_pc + 4'd1;
            end
            m_phase = m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ac",        32'(ac),        32'(m_ac));
            chk("pc",        32'(pc),        32'(m_pc));
            chk("carry",     32'(carry),     32'(m_carry));
            chk("zero",      32'(zero),      32'(m_ac == 8'h00));
            chk("running",   32'(running),   32'(m_mode == 1));
            chk("halted",    32'(halted),    32'(m_mode == 2));
            chk("mem_rdata", 32'(mem_rdata), 32'(m_mem[mem_addr]));
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        @(posedge clk); #2;
        mem_we = 1'b0;
    endtask

    // Returns 2 time units after the edge that samples start
    task automatic go(input bit ld, input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        start = 1'b1;
        if (ld) begin
            mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        end
        @(posedge clk); #2;
        start = 1'b0;
        mem_we = 1'b0;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (n < 200 && !halted) begin
            @(posedge clk); #1;
            n++;
        end
        chk("halt_reached", 32'(halted), 32'(1));
    endtask

    int n;

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_we = 1'b0; mem_addr = 4'h0; mem_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_running", 32'(running), 32'(0));
        chk("rst_halted",  32'(halted),  32'(0));
        chk("rst_zero",    32'(zero),    32'(1));
        chk("rst_carry",   32'(carry),   32'(0));
        chk("rst_ac",      32'(ac),      32'(0));
        chk("rst_pc",      32'(pc),      32'(0));
        for (int i = 0; i < 16; i++) load(4'(i), 8'h00);
        chk_en = 1'b1;

        // LDA 14; ADD 15; HLT -- last word loaded in the start cycle
        load(4'd0, 8'h4E); load(4'd1, 8'h0F); load(4'd14, 8'hF0); load(4'd15, 8'h20);
        go(1'b1, 4'd2, 8'hF0);
        wait_halt(n);
        chk("p1_latency", 32'(n),     32'(15));
        chk("p1_ac",      32'(ac),    32'(8'h10));
        chk("p1_carry",   32'(carry), 32'(1));
        chk("p1_pc",      32'(pc),    32'(3));

        // Indirect LDA through M13; host writes while running must be dropped
        do_reset();
        load(4'd0, 8'hCD); load(4'd1, 8'hF0); load(4'd13, 8'h09); load(4'd9, 8'h77);
        go(1'b0, 4'd0, 8'h00);
        @(posedge clk); #2;
        mem_we = 1'b1; mem_addr = 4'd9; mem_wdata = 8'hAA;
        repeat (2) @(posedge clk);
        #2 mem_we = 1'b0;
        wait_halt(n);
        chk("p2_ac",    32'(ac),    32'(8'h77));
        chk("p2_carry", 32'(carry), 32'(0));
        mem_addr = 4'd9;
        @(negedge clk);
        chk("p2_m9", 32'(mem_rdata), 32'(8'h77));

        // LDA 10; DBL 11; CMA 11; STA 12; HLT
        load(4'd0, 8'h4A); load(4'd1, 8'h3B); load(4'd2, 8'h6B); load(4'd3, 8'h5C);
        load(4'd4, 8'hF0); load(4'd10, 8'h81); load(4'd11, 8'hC4);
        mem_addr = 4'd11;
        go(1'b0, 4'd0, 8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("p3_lda_ac", 32'(ac), 32'(8'h81));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("p3_dbl_m11",   32'(mem_rdata), 32'(8'h88));
        chk("p3_dbl_carry", 32'(carry),     32'(1));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("p3_cma_m11", 32'(mem_rdata), 32'(8'h77));
        wait_halt(n);
        chk("p3_ac", 32'(ac), 32'(8'h81));
        mem_addr = 4'd12;
        @(negedge clk);
        chk("p3_m12", 32'(mem_rdata), 32'(8'h81));

        // JZ 14 with ac=81: not taken
        load(4'd0, 8'h7E); load(4'd1, 8'hF0);
        go(1'b0, 4'd0, 8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("jz_nt_pc", 32'(pc), 32'(1));
        wait_halt(n);
        chk("jz_nt_hlt_pc", 32'(pc), 32'(2));

        // JZ 14 with ac=0: taken, HLT at 14
        do_reset();
        go(1'b0, 4'd0, 8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("jz_t_pc", 32'(pc), 32'(14));
        wait_halt(n);
        chk("jz_t_hlt_pc", 32'(pc), 32'(15));

        // JZ 15 taken, LDA 10 at 15 wraps pc to 0, JZ not taken, HLT
        load(4'd0, 8'h7F); load(4'd15, 8'h4A); load(4'd1, 8'hF0);
        go(1'b0, 4'd0, 8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("wrap_jz_pc", 32'(pc), 32'(15));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'(0));
        wait_halt(n);
        chk("wrap_ac", 32'(ac), 32'(8'h81));
        chk("wrap_pc_end", 32'(pc), 32'(2));

        // Reset during EXECUTE of STA 12 leaves M12 intact
        load(4'd0, 8'h4A); load(4'd1, 8'h5C); load(4'd2, 8'hF0); load(4'd12, 8'h33);
        go(1'b0, 4'd0, 8'h00);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        mem_addr = 4'd12;
        @(negedge clk);
        chk("abort_m12",     32'(mem_rdata), 32'(8'h33));
        chk("abort_ac",      32'(ac),        32'(0));
        chk("abort_running", 32'(running),   32'(0));
        chk("abort_halted",  32'(halted),    32'(0));
        chk("abort_zero",    32'(zero),      32'(1));

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
